// File: rtl/sm_seq_arb_pkg.sv
// Shared types and constants for the sm_seq_arbiter round-robin pulse-sequence arbiter.
package sm_seq_arb_pkg;

    localparam int CMD_W     = 3;
    localparam int LEN_SHORT = 4;
    localparam int LEN_LONG  = 8;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // b2 selects the long path through S4..S7.
    function automatic logic [3:0] seq_len(input logic [CMD_W-1:0] cmd);
        return cmd[1] ? 4'(LEN_LONG) : 4'(LEN_SHORT);
    endfunction

    function automatic logic cmd_valid(input logic [CMD_W-1:0] cmd);
        return cmd[0] | cmd[1];
    endfunction

endpackage

// File: rtl/sm_seq_arbiter_if.sv
// Requester-side bus of sm_seq_arbiter: level requests and button codes in, grant/done/busy out.
interface sm_seq_arbiter_if
    import sm_seq_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [CMD_W*NREQ-1:0] cmd;
    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        gnt_id;
    logic [NREQ-1:0]       done;
    logic                  busy;

    modport master (output req, cmd, input gnt, gnt_id, done, busy);
    modport slave  (input req, cmd, output gnt, gnt_id, done, busy);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after i_ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    int             w_pos;
    logic [IDW-1:0] w_pos_idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a latch behind.
        o_onehot  = '0;
        o_idx     = '0;
        o_any     = 1'b0;
        w_pos     = 0;
        w_pos_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos     = (int'(i_ptr) + k) % NREQ;
            w_pos_idx = IDW'(w_pos);
            if (!o_any && i_valid[w_pos_idx]) begin
                o_any               = 1'b1;
                o_idx               = w_pos_idx;
                o_onehot[w_pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_seq_arbiter.sv
// Round-robin arbiter sharing one 3-button pulse state machine among NREQ requesters.
// Optional outp pulse-count check enabled by defining SM_SEQ_ARB_OUTP_CHECK_EN.
module sm_seq_arbiter
    import sm_seq_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    sm_seq_arbiter_if.slave  arb,
    output logic [CMD_W-1:0] o_sm_b,
    input  logic             i_sm_outp,
    output logic             o_err,
    input  logic             i_err_clr
);

    state_e           r_state,  w_state_n;
    logic [NREQ-1:0]  r_gnt,    w_gnt_n;
    logic [IDW-1:0]   r_gnt_id, w_gnt_id_n;
    logic [NREQ-1:0]  r_done,   w_done_n;
    logic             r_busy,   w_busy_n;
    logic [CMD_W-1:0] r_sm_b,   w_sm_b_n;
    logic [CNT_W-1:0] r_cnt,    w_cnt_n;
    logic [IDW-1:0]   r_rr_ptr, w_rr_ptr_n;
    logic             w_leave_run;

    logic [NREQ-1:0]  w_valid;
    logic [NREQ-1:0]  w_onehot;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [CMD_W-1:0] w_win_cmd;

    always_comb begin
        w_valid   = '0;
        w_win_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_valid[i] = arb.req[i] & cmd_valid(arb.cmd[i*CMD_W +: CMD_W]);
            if (w_onehot[i]) w_win_cmd = arb.cmd[i*CMD_W +: CMD_W];
        end
    end

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .i_valid  (w_valid),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    always_comb begin
        w_state_n   = r_state;
        w_gnt_n     = r_gnt;
        w_gnt_id_n  = r_gnt_id;
        w_done_n    = '0;
        w_busy_n    = r_busy;
        w_sm_b_n    = r_sm_b;
        w_cnt_n     = r_cnt;
        w_rr_ptr_n  = r_rr_ptr;
        w_leave_run = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_n    = w_onehot;
                    w_gnt_id_n = w_idx;
                    w_sm_b_n   = w_win_cmd;
                    w_cnt_n    = CNT_W'(seq_len(w_win_cmd) - 4'd1);
                    w_busy_n   = 1'b1;
                    w_rr_ptr_n = (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);
                    w_state_n  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end else begin
                    w_sm_b_n    = '0;
                    w_gnt_n     = '0;
                    w_done_n    = r_gnt;
                    w_leave_run = 1'b1;
                    w_state_n   = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy_n  = 1'b0;
                w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_sm_b   <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_n;
            r_gnt    <= w_gnt_n;
            r_gnt_id <= w_gnt_id_n;
            r_done   <= w_done_n;
            r_busy   <= w_busy_n;
            r_sm_b   <= w_sm_b_n;
            r_cnt    <= w_cnt_n;
            r_rr_ptr <= w_rr_ptr_n;
        end
    end

    assign arb.gnt    = r_gnt;
    assign arb.gnt_id = r_gnt_id;
    assign arb.done   = r_done;
    assign arb.busy   = r_busy;
    assign o_sm_b     = r_sm_b;

`ifdef SM_SEQ_ARB_OUTP_CHECK_EN
    logic [1:0] r_pulse_cnt;
    logic [1:0] w_pulse_final;
    logic [1:0] w_pulse_exp;
    logic       w_mismatch;
    logic       r_err;

    // Count includes the final RUN cycle so the check can fire on the exit edge.
    assign w_pulse_final = (i_sm_outp && r_pulse_cnt != 2'd3) ? r_pulse_cnt + 2'd1 : r_pulse_cnt;
    assign w_pulse_exp   = r_sm_b[2] ? 2'd2 : 2'd1;
    assign w_mismatch    = w_leave_run && (w_pulse_final != w_pulse_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_any) r_pulse_cnt <= '0;
            else if (r_state == ST_RUN)      r_pulse_cnt <= w_pulse_final;
            if (w_mismatch)     r_err <= 1'b1;
            else if (i_err_clr) r_err <= 1'b0;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_chk;
    assign w_unused_chk = i_sm_outp ^ i_err_clr;
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sm_seq_arbiter.sv
// Self-checking bench for sm_seq_arbiter against a cycle-timeline reference model.
module tb_sm_seq_arbiter;

    localparam int NREQ = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sm_outp = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] sm_b;
    logic       err;

    sm_seq_arbiter_if #(.NREQ(NREQ)) bus ();

    sm_seq_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb       (bus),
        .o_sm_b    (sm_b),
        .i_sm_outp (sm_outp),
        .o_err     (err),
        .i_err_clr (err_clr)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         m_active;
    int         m_t0, m_len, m_win, m_gid, m_rr, m_pcnt;
    logic [2:0] m_cmd;
    bit         m_err;
    bit         kill_outp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int code_len(input logic [2:0] c);
        return c[1] ? 8 : 4;
    endfunction

    function automatic bit code_ok(input logic [2:0] c);
        return c[0] | c[1];
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_rr     = 0;
        m_gid    = 0;
        m_err    = 1'b0;
        m_pcnt   = 0;
    endtask

    // Advance the model across one rising edge using the inputs sampled there.
    task automatic model_edge();
        int         off;
        logic [2:0] c;
        if (!rst_n) begin
            model_reset();
            cyc++;
            return;
        end
        off = cyc - m_t0;
        if (m_active && off >= 1 && off <= m_len && sm_outp) m_pcnt++;
`ifdef SM_SEQ_ARB_OUTP_CHECK_EN
        if (m_active && off == m_len && m_pcnt != 1 + int'(m_cmd[2])) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
`endif
        if (!m_active) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                c = bus.cmd[j*3 +: 3];
                if (!m_active && bus.req[j] && code_ok(c)) begin
                    m_active = 1'b1;
                    m_t0     = cyc;
                    m_win    = j;
                    m_gid    = j;
                    m_cmd    = c;
                    m_len    = code_len(c);
                    m_rr     = (j + 1) % NREQ;
                    m_pcnt   = 0;
                end
            end
        end else if (off == m_len + 1) begin
            m_active = 1'b0;
        end
        cyc++;
    endtask

    task automatic compare();
        int         off;
        logic [3:0] e_gnt, e_done;
        logic       e_busy;
        logic [2:0] e_smb;
        e_gnt = '0; e_done = '0; e_busy = 1'b0; e_smb = '0;
        off = cyc - m_t0;
        if (m_active && off >= 1 && off <= m_len) begin
            e_gnt  = 4'(1 << m_win);
            e_smb  = m_cmd;
            e_busy = 1'b1;
        end else if (m_active && off == m_len + 1) begin
            e_done = 4'(1 << m_win);
            e_busy = 1'b1;
        end
        check("gnt", 32'(bus.gnt), 32'(e_gnt));
        check("gnt_id", 32'(bus.gnt_id), 32'(m_gid));
        check("done", 32'(bus.done), 32'(e_done));
        check("busy", 32'(bus.busy), 32'(e_busy));
        check("sm_b", 32'(sm_b), 32'(e_smb));
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        check("err", 32'(err), 32'(m_err));
    endtask

    // Stand-in for the state machine's outp: S3 at offset 4, S2 at offset 3 when b3 is set.
    task automatic drive_outp();
        int off;
        off = cyc - m_t0;
        sm_outp = m_active && !kill_outp && (off == 4 || (off == 3 && m_cmd[2]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        drive_outp();
    endtask

    function automatic logic [2:0] rand_valid_code();
        logic [2:0] c;
        c = 3'($urandom_range(1, 7));
        if (c == 3'b100) c = 3'b101;
        return c;
    endfunction

    initial begin
        bit got;
        bus.req = '0;
        bus.cmd = '0;
        model_reset();
        #2;
        compare();
        repeat (3) step();
        #2 rst_n = 1'b1;

        // Long sequence from requester 0.
        bus.req[0] = 1'b1;
        bus.cmd[2:0] = 3'b011;
        repeat (9) step();
        bus.req[0] = 1'b0;
        repeat (3) step();

        // Short sequence with b3 from requester 1.
        bus.req[1] = 1'b1;
        bus.cmd[5:3] = 3'b101;
        repeat (5) step();
        bus.req[1] = 1'b0;
        repeat (3) step();

        // All four held continuously with valid codes.
        for (int i = 0; i < NREQ; i++) bus.cmd[i*3 +: 3] = rand_valid_code();
        bus.req = '1;
        repeat (50) step();
        bus.req = '0;
        repeat (12) step();

        // Invalid code 100 alone is never granted.
        bus.cmd[8:6] = 3'b100;
        bus.req[2] = 1'b1;
        repeat (20) step();
        check("invalid_busy", 32'(bus.busy), 32'd0);
        bus.req[2] = 1'b0;
        repeat (2) step();

        // Reset in the middle of an 8-cycle sequence.
        bus.cmd[2:0]  = 3'b011;
        bus.cmd[11:9] = 3'b110;
        bus.req[0] = 1'b1;
        bus.req[3] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (m_active && cyc - m_t0 == 3) got = 1'b1;
        end
        check("grant_wait", 32'(got), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        check("rst_sm_b", 32'(sm_b), 32'd0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 5 && !got; n++) begin
            step();
            if (bus.busy) got = 1'b1;
        end
        check("regrant_seen", 32'(got), 32'd1);
        check("regrant_id", 32'(bus.gnt_id), 32'd0);
        check("regrant_gnt", 32'(bus.gnt), 32'd1);
        repeat (20) step();
        bus.req = '0;
        repeat (12) step();

`ifdef SM_SEQ_ARB_OUTP_CHECK_EN
        // Missing outp pulses must raise err; err_clr drops it.
        bus.req[1] = 1'b1;
        bus.cmd[5:3] = 3'b101;
        kill_outp = 1'b1;
        repeat (6) step();
        bus.req[1] = 1'b0;
        kill_outp = 1'b0;
        repeat (2) step();
        check("err_set", 32'(err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        check("err_clr", 32'(err), 32'd0);
`endif

        // Randomized request/code traffic.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
                if ($urandom_range(0, 7) == 0) bus.cmd[i*3 +: 3] = 3'($urandom_range(0, 7));
            end
`ifdef SM_SEQ_ARB_OUTP_CHECK_EN
            err_clr = ($urandom_range(0, 15) == 0);
`endif
            step();
        end
        bus.req = '0;
        err_clr = 1'b0;
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_seq_arbiter.md
# sm_seq_arbiter

Round-robin arbiter and sequencer that shares one 3-button pulse state machine (`b[3:1]` in, `outp` out) among `NREQ` requesters. Each requester presents a 3-bit button code; the arbiter grants one requester at a time, drives its code onto the state machine's `b` inputs for exactly the length of the resulting sequence, then returns `b` to zero and pulses `done` to the winner. It sits between requesting control logic and the state machine instance, and shares `clk` and `rst_n` with it.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(NREQ)`: grant-index width, derived.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req` in NREQ: level request per requester.
- `cmd` in 3*NREQ: button code per requester; requester i drives `cmd[3i+2:3i]` as `{b3,b2,b1}`.
- `gnt` out NREQ: one-hot grant, registered.
- `gnt_id` out IDW: index of the current grantee, registered.
- `done` out NREQ: one-cycle completion pulse, one-hot.
- `busy` out 1: sequence in progress.
- `sm_b` out 3: drives the state machine's `b[3:1]`, registered.
- `sm_outp` in 1: the state machine's `outp`.
- `err` out 1: sticky pulse-check error (see Configuration).
- `err_clr` in 1: synchronous clear for `err`.

## Operation
- Valid request: `req[i]=1` and `cmd_i[1]|cmd_i[2]=1`. Requests with codes 000/100 are never granted and produce no `done`.
- Sequence length L = 8 if `cmd[2]=1`, else 4. This matches the state machine path S0→S3→(S4..S7)→S0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any valid request exists, the round-robin pick is the first valid index at or after `rr_ptr`, wrapping.
  - On that edge: `gnt` set to the winner's one-hot, `gnt_id` set, `sm_b` loaded from the winner's `cmd`, `cnt` set to L-1, `busy` set to 1, `rr_ptr` set to winner+1 mod NREQ, state → RUN.
- RUN:
  - `sm_b` is held constant.
  - While `cnt≠0`, `cnt` decrements each cycle.
  - When `cnt=0`: `sm_b` set to 0, `gnt` set to 0, `done` set to the winner's one-hot, state → DONE.
- DONE: `done` is cleared, `busy` is cleared, state → IDLE.
- `cmd` is latched at grant. Changes to `req`/`cmd` after grant are ignored until `done`.
- Requester protocol:
  - Hold `req` until `done`.
  - A requester that keeps `req` high re-enters arbitration at normal round-robin priority.
- Reset values: state IDLE, `rr_ptr=0`, `gnt=0`, `gnt_id=0`, `done=0`, `busy=0`, `sm_b=000`, `err=0`, `cnt=0`.
- Reset mid-sequence: all outputs return to reset values at once. The state machine resets on the same `rst_n`, so no stale `b` is left applied.

## Timing
- Cycle T (IDLE, valid request sampled) → `sm_b`/`gnt`/`busy` valid in cycle T+1. Request-to-drive latency is 1 cycle.
- `sm_b` holds for cycles T+1..T+L. The state machine is in S0 at T+1 and back in S0 at T+L+1.
- `done` and `busy` are both high in cycle T+L+1 only for `done`; `sm_b=0` from T+L+1 on.
- The next arbitration happens in cycle T+L+2. Minimum grant period is L+2 cycles, which guarantees at least one S0 cycle with `b=0` between sequences.
- Simultaneous requests are resolved purely by `rr_ptr`. There is no starvation: worst-case wait is (NREQ-1)·10 cycles.

## Configuration
- `SM_SEQ_ARB_OUTP_CHECK_EN` defined:
  - During RUN, count cycles with `sm_outp=1` using a 2-bit saturating counter that is cleared at grant.
  - Expected count is 1 + `cmd[3]` (S3 always; S2 also when b3 is set).
  - On the edge leaving RUN, a mismatch sets `err`.
  - `err` stays set until `err_clr` or reset. `err_clr` and a new mismatch in the same cycle leave `err` set.
- Undefined: `err` is tied to 0, and `sm_outp` and `err_clr` are unused.

## Structure
- Package `sm_seq_arb_pkg`:
  - State enum (IDLE/RUN/DONE).
  - `LEN_SHORT=4`, `LEN_LONG=8`.
  - `CMD_W=3`.
  - Function returning L from a cmd.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs are the valid vector and `rr_ptr`; outputs are a one-hot and an index, plus `any`.

## Test plan
- Reset, then `req0=1`, `cmd0=011` at cycle T → `sm_b=011` for T+1..T+8, `done[0]` at T+9, state machine `outp` high only at T+4, `err=0`.
- `req1=1`, `cmd1=101` → L=4; `outp` high at T+3 and T+4; `done[1]` at T+5; next grant no earlier than T+6.
- All four requesters valid, held continuously → grants in order 0,1,2,3,0, each separated by L+2 cycles, `gnt` always one-hot or zero.
- `req2=1` with `cmd2=100` and no other request → no grant, `busy=0`, `sm_b=000` indefinitely.
- `rst_n` low at T+3 of an 8-cycle sequence → `sm_b`, `gnt`, `busy` zero immediately; after release, the pending request is re-granted with `rr_ptr=0`.
- With the macro defined, force `sm_outp=0` during a `cmd=101` run → `err=1` after RUN; `err_clr` pulse → `err=0`.
